// File: rtl/serial_add_scheduler.sv
// rtl/serial_add_scheduler.sv - round-robin scheduler sharing one bit-serial adder between two requesters
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   req0_vld/a/b, req0_rdy    requester 0 operand handshake
//   req1_vld/a/b, req1_rdy    requester 1 operand handshake
//   ser_clr                   active-high clear to the serial adder (= ~rst)
//   ser_vld/a/b/last          LSB-first operand bits and framing to the adder
//   ser_sum                   combinational sum bit returned by the adder
//   res_vld/id/sum, res_rdy   tagged W-bit result handshake
module serial_add_scheduler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_vld,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_rdy,
    input  logic         req1_vld,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_rdy,
    output logic         ser_clr,
    output logic         ser_vld,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_last,
    input  logic         ser_sum,
    output logic         res_vld,
    output logic         res_id,
    output logic [W-1:0] res_sum,
    input  logic         res_rdy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           rr;
    logic           id_q;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    // Only the W-1 most recent sum bits need storing; the current bit
    // arrives combinationally and completes the word.
    logic [W-2:0]   acc;
    logic [W-1:0]   sum_nxt;
    logic [W-1:0]   res_q;
    logic           grant_id;
    logic           grant;
    logic           cnt_last;

    always_comb begin
        grant_id = (req0_vld & req1_vld) ? rr : req1_vld;
        // Gate with rst so no operands are handed over while reset is asserted.
        grant    = rst & (state == IDLE) & (req0_vld | req1_vld);
        cnt_last = (cnt == CNT_LAST);
        sum_nxt  = {ser_sum, acc};
    end

    assign req0_rdy = grant & ~grant_id;
    assign req1_rdy = grant & grant_id;

    // Adder carry clears in the same cycles this block is held in reset.
    assign ser_clr  = ~rst;
    assign ser_vld  = rst & (state == SHIFT);
    assign ser_a    = ser_vld & a_sh[0];
    assign ser_b    = ser_vld & b_sh[0];
    assign ser_last = ser_vld & cnt_last;

    assign res_vld  = rst & (state == DONE);
    assign res_id   = id_q;
    assign res_sum  = res_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SHIFT;
            SHIFT:   if (cnt_last) state_nxt = DONE;
            DONE:    if (res_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr    <= 1'b0;
            id_q  <= 1'b0;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        a_sh <= grant_id ? req1_a : req0_a;
                        b_sh <= grant_id ? req1_b : req0_b;
                        id_q <= grant_id;
                        rr   <= ~grant_id;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    acc  <= sum_nxt[W-1:1];
                    cnt  <= cnt + CW'(1);
                    if (cnt_last) begin
                        res_q <= sum_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb/tb_serial_add_scheduler.sv - directed and random self-checking bench for serial_add_scheduler
module tb_serial_add_scheduler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_vld, req1_vld;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_rdy, req1_rdy;
    logic         ser_clr, ser_vld, ser_a, ser_b, ser_last, ser_sum;
    logic         res_vld, res_id, res_rdy;
    logic [W-1:0] res_sum;

    int   checks = 0;
    int   errors = 0;
    logic rr_m   = 1'b0;
    logic carry  = 1'b0;

    always #5 clk = ~clk;

    serial_add_scheduler #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_a(req0_a), .req0_b(req0_b), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_a(req1_a), .req1_b(req1_b), .req1_rdy(req1_rdy),
        .ser_clr(ser_clr), .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b),
        .ser_last(ser_last), .ser_sum(ser_sum),
        .res_vld(res_vld), .res_id(res_id), .res_sum(res_sum), .res_rdy(res_rdy)
    );

    // Bit-serial adder model: carry clears on ser_clr and after the last bit.
    always @(posedge clk) begin
        if (ser_clr) carry <= 1'b0;
        else if (ser_vld) carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (ser_a & carry) | (ser_b & carry));
    end
    assign ser_sum = ser_a ^ ser_b ^ carry;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; returns on the negedge of the grant cycle.
    task automatic get_grant(output logic id, output int waited);
        logic exp_id;
        waited = 0;
        id = 1'b0;
        @(negedge clk);
        check("res_vld_idle", res_vld, 1'b0);
        while (!(req0_rdy | req1_rdy) && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        check("grant_seen", req0_rdy | req1_rdy, 1'b1);
        id = req1_rdy;
        check("one_rdy", req0_rdy & req1_rdy, 1'b0);
        exp_id = (req0_vld & req1_vld) ? rr_m : req1_vld;
        check("grant_id", id, exp_id);
        rr_m = ~id;
    endtask

    // Follows one granted operation through serialization and result handshake;
    // returns just after the rising edge that completes the handshake.
    task automatic serve(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int hold, input bit drop);
        logic [W-1:0] sa, sb, lm, lexp;
        logic s0, s1;
        lexp = '0;
        lexp[W-1] = 1'b1;
        res_rdy = (hold == 0);
        @(posedge clk) #1;
        if (drop) begin
            req0_vld = 1'b0; req1_vld = 1'b0;
            req0_a = ~req0_a; req0_b = ~req0_b; req1_a = ~req1_a; req1_b = ~req1_b;
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("ser_vld_run", ser_vld, 1'b1);
            check("rdy_busy", req0_rdy | req1_rdy, 1'b0);
            sa[i] = ser_a;
            sb[i] = ser_b;
            lm[i] = ser_last;
        end
        check("ser_a_bits", sa, a);
        check("ser_b_bits", sb, b);
        check("ser_last_pos", lm, lexp);
        @(negedge clk);
        check("res_vld", res_vld, 1'b1);
        check("res_sum", res_sum, exp);
        check("res_id", res_id, id);
        check("ser_vld_done", ser_vld, 1'b0);
        if (hold > 0) begin
            s0 = req0_vld;
            s1 = req1_vld;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk) #1;
                req0_vld = 1'b1;
                req1_vld = 1'b1;
                @(negedge clk);
                check("hold_vld", res_vld, 1'b1);
                check("hold_sum", res_sum, exp);
                check("hold_id", res_id, id);
                check("hold_rdy", req0_rdy | req1_rdy, 1'b0);
                check("hold_ser", ser_vld, 1'b0);
            end
            @(posedge clk) #1;
            req0_vld = s0;
            req1_vld = s1;
            res_rdy = 1'b1;
            @(negedge clk);
            check("hs_vld", res_vld, 1'b1);
        end
        @(posedge clk) #1;
    endtask

    task automatic run_op(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int hold, output int waited);
        logic id;
        if (who) begin
            req1_vld = 1'b1; req1_a = a; req1_b = b; req0_vld = 1'b0;
        end else begin
            req0_vld = 1'b1; req0_a = a; req0_b = b; req1_vld = 1'b0;
        end
        get_grant(id, waited);
        check("op_who", id, who);
        serve(who, a, b, exp, hold, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic id;
        int   w;
        logic [W-1:0] a0, b0, a1, b1, e;
        int   mode;

        rst = 1'b0;
        res_rdy = 1'b1;
        req0_vld = 1'b1; req1_vld = 1'b0;
        req0_a = 8'h11; req0_b = 8'h22; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_res_vld", res_vld, 1'b0);
        check("rst_res_sum", res_sum, 8'h00);
        check("rst_res_id", res_id, 1'b0);
        check("rst_ser_vld", ser_vld, 1'b0);
        check("rst_ser_last", ser_last, 1'b0);
        check("rst_rdy", req0_rdy | req1_rdy, 1'b0);
        check("rst_ser_clr", ser_clr, 1'b1);
        @(posedge clk) #1;
        rst = 1'b1;
        req0_vld = 1'b0;
        @(negedge clk);
        check("run_ser_clr", ser_clr, 1'b0);
        @(posedge clk) #1;

        // Basic op and wrap-around / carry clear
        run_op(1'b0, 8'h5A, 8'h33, 8'h8D, 0, w);
        check("t1_wait", w, 0);
        run_op(1'b1, 8'hFF, 8'h01, 8'h00, 0, w);
        run_op(1'b0, 8'h01, 8'h01, 8'h02, 0, w);

        // Alternation with both requesters held valid after reset
        rst = 1'b0;
        @(posedge clk) #1;
        rst = 1'b1;
        rr_m = 1'b0;
        req0_a = 8'd1; req0_b = 8'd2; req1_a = 8'd3; req1_b = 8'd4;
        req0_vld = 1'b1; req1_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            get_grant(id, w);
            check("alt_grant", id, k[0]);
            serve(id, id ? 8'd3 : 8'd1, id ? 8'd4 : 8'd2, id ? 8'd7 : 8'd3, 0, 1'b0);
        end
        req0_vld = 1'b0; req1_vld = 1'b0;

        // Result backpressure, then an immediate grant after the handshake
        run_op(1'b0, 8'h12, 8'h34, 8'h46, 5, w);
        run_op(1'b1, 8'h0A, 8'h05, 8'h0F, 0, w);
        check("grant_after_hs", w, 0);

        // Reset in the middle of SHIFT
        req0_a = 8'hF0; req0_b = 8'h0F; req0_vld = 1'b1;
        get_grant(id, w);
        @(posedge clk) #1;
        req0_vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("pre_rst_ser", ser_vld, 1'b1);
        end
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_clr", ser_clr, 1'b1);
        check("mid_rst_ser", ser_vld, 1'b0);
        check("mid_rst_res", res_vld, 1'b0);
        @(posedge clk) #1;
        rst = 1'b1;
        rr_m = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_ser", ser_vld, 1'b0);
            check("post_rst_res", res_vld, 1'b0);
        end
        @(posedge clk) #1;
        req0_a = 8'h10; req0_b = 8'h20; req1_a = 8'h01; req1_b = 8'h01;
        req0_vld = 1'b1; req1_vld = 1'b1;
        get_grant(id, w);
        check("rr_after_rst", id, 1'b0);
        serve(1'b0, 8'h10, 8'h20, 8'h30, 0, 1'b1);

        // Random operands, requester mix and result backpressure
        for (int n = 0; n < 200; n++) begin
            mode = $urandom_range(0, 2);
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
            req0_vld = (mode != 1);
            req1_vld = (mode != 0);
            get_grant(id, w);
            e = id ? (a1 + b1) : (a0 + b0);
            serve(id, id ? a1 : a0, id ? b1 : b0, e, $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
- Controller that shares one bit-serial adder (inputs vld/a/b/last, combinational sum output, active-high reset) between two requesters.
- Each requester hands over a pair of W-bit operands with a valid/ready handshake.
- The block round-robin arbitrates between requesters and serializes the operands LSB-first into the adder with vld/last framing.
- It deserializes the returned sum bits and presents a W-bit result, tagged with the requester id, on a valid/ready output.

Parameters:
- W, 8, operand/result width in bits (W >= 2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset: rst==0 at a rising clk edge resets the block.
- req0_vld  input  1  requester 0 has operands.
- req0_a  input  W  requester 0 operand A.
- req0_b  input  W  requester 0 operand B.
- req0_rdy  output  1  requester 0 operands accepted this cycle.
- req1_vld  input  1  requester 1 has operands.
- req1_a  input  W  requester 1 operand A.
- req1_b  input  W  requester 1 operand B.
- req1_rdy  output  1  requester 1 operands accepted this cycle.
- ser_clr  output  1  active-high clear to the adder's reset input.
- ser_vld  output  1  to adder vld.
- ser_a  output  1  to adder a.
- ser_b  output  1  to adder b.
- ser_last  output  1  to adder last.
- ser_sum  input  1  from adder sum (combinational, same cycle).
- res_vld  output  1  result valid.
- res_id  output  1  requester that issued the result.
- res_sum  output  W  (A+B) mod 2^W; final carry discarded.
- res_rdy  input  1  consumer takes the result.

Behaviour:
- ser_clr = ~rst, combinational, so the adder carry clears together with this block.
- Reset values: state=IDLE, rr pointer=0, res_vld=0, res_id=0, res_sum=0, ser_vld=ser_a=ser_b=ser_last=0, req*_rdy=0, bit counter=0.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, arbitration:
  - If exactly one reqX_vld is high, grant it.
  - If both are high, grant the requester equal to the rr pointer.
  - reqX_rdy is combinational, high only in IDLE for the granted requester.
  - On a grant, capture reqX_a/b into shift registers a_sh/b_sh, set id=X, set rr pointer=~X, clear the counter, go to SHIFT.
  - If no request, stay in IDLE; the pointer is unchanged.
- SHIFT (exactly W cycles):
  - ser_vld=1, ser_a=a_sh[0], ser_b=b_sh[0].
  - ser_last=1 only when counter==W-1.
  - Each cycle: a_sh/b_sh shift right, sum_sh <= {ser_sum, sum_sh[W-1:1]}, counter increments.
  - After the cycle with counter==W-1, go to DONE and load res_sum from the final sum_sh value, including that cycle's ser_sum bit.
- DONE:
  - res_vld=1; res_sum and res_id are held stable.
  - Outside SHIFT, ser_vld/ser_a/ser_b/ser_last are all 0.
  - On res_vld & res_rdy, res_vld drops next cycle and the state returns to IDLE.
  - No new grant is made in the handshake cycle.
- Latency: grant in cycle T; serial bits in T+1..T+W; res_vld=1 from T+W+1. Minimum issue period W+2 cycles.
- Requests are never accepted outside IDLE; reqX_vld may toggle freely while not granted.
- Operands are sampled only in the grant cycle; later input changes do not affect the operation in flight.
- Reset mid-operation (any state):
  - The operation is dropped: no result, no further ser_vld.
  - The adder carry is cleared via ser_clr.
  - The rr pointer returns to 0.
- Wrap-around: the sum is modulo 2^W and the carry out is discarded.

Test Plan:
- W=8, req0 a=8'h5A b=8'h33, res_rdy=1 → req0_rdy pulses once. ser_vld high 8 cycles with ser_a bits 0,1,0,1,1,0,1,0 (LSB first). ser_last only on the 8th cycle. res_vld=1 one cycle later with res_sum=8'h8D, res_id=0.
- Overflow: req1 a=8'hFF b=8'h01 → res_sum=8'h00, res_id=1. The next op, a=8'h01 b=8'h01, gives 8'h02, proving the carry is cleared by last.
- Both requesters held valid for 4 operations after reset (req0: 1+2, req1: 3+4) → grants alternate 0,1,0,1. Results 3,7,3,7 with res_id 0,1,0,1.
- Backpressure: res_rdy=0 for 5 cycles after res_vld rises → res_vld, res_sum, res_id stable. No reqX_rdy, ser_vld stays 0. Next request is granted the cycle after the res_rdy handshake.
- Reset mid-SHIFT: rst=0 after 3 serial bits of a=8'hF0 b=8'h0F → ser_clr=1, ser_vld=0, res_vld=0, no result emitted. After release, a=8'h10 b=8'h20 → res_sum=8'h30.
- Random: 200 random operand pairs from both requesters with random res_rdy → every result equals (a+b) mod 256 with the correct id. Exactly one ser_last per operation, no ser_vld gaps within an operation.
